// File: rtl/btn_click_ctrl.sv
// btn_click_ctrl: mouse left-button debounce, button hit test, click-to-action
// pulses and the blackjack round-phase FSM that decides which buttons are live.
module btn_click_ctrl #(
    parameter int BTN_Y           = 400,
    parameter int BTN_W           = 100,
    parameter int BTN_H           = 50,
    parameter int DEAL_X          = 100,
    parameter int HIT_X           = 300,
    parameter int STAND_X         = 500,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        left,
    input  logic        player_bust,
    input  logic        dealer_done,
    output logic        deal_pulse,
    output logic        hit_pulse,
    output logic        stand_pulse,
    output logic [2:0]  btn_en,
    output logic [1:0]  phase
);

    typedef enum logic [1:0] {IDLE, PLAYER, DEALER, RESULT} phase_t;
    typedef enum logic [1:0] {BTN_NONE, BTN_DEAL, BTN_HIT, BTN_STAND} btn_t;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [11:0] Y_LO     = 12'(BTN_Y);
    localparam logic [11:0] Y_HI     = 12'(BTN_Y + BTN_H);
    localparam logic [11:0] DEAL_LO  = 12'(DEAL_X);
    localparam logic [11:0] DEAL_HI  = 12'(DEAL_X + BTN_W);
    localparam logic [11:0] HIT_LO   = 12'(HIT_X);
    localparam logic [11:0] HIT_HI   = 12'(HIT_X + BTN_W);
    localparam logic [11:0] STAND_LO = 12'(STAND_X);
    localparam logic [11:0] STAND_HI = 12'(STAND_X + BTN_W);

    logic          sync1, sync2;
    logic          db, db_prev;
    logic [CW-1:0] cnt;
    btn_t          over, armed;
    phase_t        state;
    logic          press, release_ev, fire;
    logic          fire_deal, fire_hit, fire_stand;

    // Enable bit for a given button id; NONE is never enabled.
    function automatic logic en_of(input btn_t id, input logic [2:0] en);
        case (id)
            BTN_DEAL:  en_of = en[0];
            BTN_HIT:   en_of = en[1];
            BTN_STAND: en_of = en[2];
            default:   en_of = 1'b0;
        endcase
    endfunction

    // Two-flop synchroniser on the raw button level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= left;
            sync2 <= sync1;
        end
    end

    // Debounce: the level only follows the synced input after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db      <= 1'b0;
            db_prev <= 1'b0;
            cnt     <= '0;
        end else begin
            db_prev <= db;
            if (sync2 != db) begin
                if (cnt == CNT_MAX) begin
                    db  <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Hit test with inclusive left/top and exclusive right/bottom edges.
    always_comb begin
        over = BTN_NONE;
        if (ypos >= Y_LO && ypos < Y_HI) begin
            if (xpos >= DEAL_LO && xpos < DEAL_HI)        over = BTN_DEAL;
            else if (xpos >= HIT_LO && xpos < HIT_HI)     over = BTN_HIT;
            else if (xpos >= STAND_LO && xpos < STAND_HI) over = BTN_STAND;
        end
    end

    assign press      = db & ~db_prev;
    assign release_ev = ~db & db_prev;
    // A click completes only if released over the armed button while it is
    // still enabled; dragging out and back in before release is fine.
    assign fire       = release_ev && (armed != BTN_NONE) && (over == armed)
                        && en_of(armed, btn_en);
    assign fire_deal  = fire && (armed == BTN_DEAL);
    assign fire_hit   = fire && (armed == BTN_HIT);
    assign fire_stand = fire && (armed == BTN_STAND);

    // Arm on press, resolve on release into a single registered action pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed       <= BTN_NONE;
            deal_pulse  <= 1'b0;
            hit_pulse   <= 1'b0;
            stand_pulse <= 1'b0;
        end else begin
            deal_pulse  <= fire_deal;
            hit_pulse   <= fire_hit;
            stand_pulse <= fire_stand;
            if (press)
                armed <= (over != BTN_NONE && en_of(over, btn_en)) ? over : BTN_NONE;
            else if (release_ev)
                armed <= BTN_NONE;
        end
    end

    // Round-phase FSM; moves on the same edge that registers the pulse, and
    // a bust arriving with a stand takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            btn_en <= 3'b001;
        end else begin
            case (state)
                IDLE, RESULT: begin
                    if (fire_deal) begin
                        state  <= PLAYER;
                        btn_en <= 3'b110;
                    end
                end
                PLAYER: begin
                    if (player_bust) begin
                        state  <= RESULT;
                        btn_en <= 3'b001;
                    end else if (fire_stand) begin
                        state  <= DEALER;
                        btn_en <= 3'b000;
                    end
                end
                DEALER: begin
                    if (dealer_done) begin
                        state  <= RESULT;
                        btn_en <= 3'b001;
                    end
                end
                default: begin
                    state  <= IDLE;
                    btn_en <= 3'b001;
                end
            endcase
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_btn_click_ctrl.sv
// Bench for btn_click_ctrl: directed scenario tasks plus a randomized run
// scored every cycle against a behavioural model of the click rules.
module tb_btn_click_ctrl;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] xpos = '0, ypos = '0;
    logic        left = 1'b0, player_bust = 1'b0, dealer_done = 1'b0;
    logic        deal_pulse, hit_pulse, stand_pulse;
    logic [2:0]  btn_en;
    logic [1:0]  phase;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    btn_click_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .left(left),
        .player_bust(player_bust), .dealer_done(dealer_done),
        .deal_pulse(deal_pulse), .hit_pulse(hit_pulse), .stand_pulse(stand_pulse),
        .btn_en(btn_en), .phase(phase)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // hist holds the last DB+1 sampled left levels (oldest first).
    bit hist[$];
    bit n_hist[$];
    bit m_db, m_dbp, n_db, n_dbp;
    int m_armed, n_armed, m_phase, n_phase;
    bit m_dp, m_hp, m_sp, n_dp, n_hp, n_sp;

    function automatic int over_btn(input int x, input int y);
        if (y < 400 || y >= 450) return 0;
        if (x >= 100 && x < 200) return 1;
        if (x >= 300 && x < 400) return 2;
        if (x >= 500 && x < 600) return 3;
        return 0;
    endfunction

    // IDLE/RESULT: only DEAL; PLAYER: HIT and STAND; DEALER: nothing.
    function automatic bit enabled(input int ph, input int id);
        if (id == 1) return (ph == 0 || ph == 3);
        if (id == 2 || id == 3) return (ph == 1);
        return 1'b0;
    endfunction

    function automatic logic [2:0] en_mask(input int ph);
        return {enabled(ph, 3), enabled(ph, 2), enabled(ph, 1)};
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i <= DB; i++) hist.push_back(1'b0);
        m_db = 0; m_dbp = 0; m_armed = 0; m_phase = 0;
        m_dp = 0; m_hp = 0; m_sp = 0;
    endtask

    task automatic model_calc();
        bit fall, rise, stable, fire;
        int o;
        if (!rst) begin
            n_hist.delete();
            for (int i = 0; i <= DB; i++) n_hist.push_back(1'b0);
            n_db = 0; n_dbp = 0; n_armed = 0; n_phase = 0;
            n_dp = 0; n_hp = 0; n_sp = 0;
            return;
        end
        fall = m_dbp && !m_db;
        rise = !m_dbp && m_db;
        o = over_btn(int'(xpos), int'(ypos));
        fire = fall && m_armed != 0 && o == m_armed && enabled(m_phase, m_armed);
        n_dp = fire && m_armed == 1;
        n_hp = fire && m_armed == 2;
        n_sp = fire && m_armed == 3;
        if (rise) n_armed = (o != 0 && enabled(m_phase, o)) ? o : 0;
        else if (fall) n_armed = 0;
        else n_armed = m_armed;
        case (m_phase)
            0: n_phase = n_dp ? 1 : 0;
            1: n_phase = player_bust ? 3 : (n_sp ? 2 : 1);
            2: n_phase = dealer_done ? 3 : 2;
            default: n_phase = n_dp ? 1 : 3;
        endcase
        // The level changes once DB samples (delayed by the 2-flop sync)
        // have all disagreed with it.
        stable = 1'b1;
        for (int i = 0; i < DB; i++) if (hist[i] == m_db) stable = 1'b0;
        n_db = stable ? !m_db : m_db;
        n_dbp = m_db;
        n_hist = hist;
        n_hist.push_back(left);
        void'(n_hist.pop_front());
    endtask

    task automatic model_commit();
        hist = n_hist;
        m_db = n_db; m_dbp = n_dbp; m_armed = n_armed; m_phase = n_phase;
        m_dp = n_dp; m_hp = n_hp; m_sp = n_sp;
    endtask

    task automatic step();
        model_calc();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // Per-cycle scoreboard, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && rst) begin
                tests++;
                if ({deal_pulse, hit_pulse, stand_pulse, btn_en, phase} !==
                    {m_dp, m_hp, m_sp, en_mask(m_phase), 2'(m_phase)}) begin
                    fails++;
                    $display("FAIL scoreboard t=%0t got p=%b%b%b en=%b ph=%0d want p=%b%b%b en=%b ph=%0d",
                             $time, deal_pulse, hit_pulse, stand_pulse, btn_en, phase,
                             m_dp, m_hp, m_sp, en_mask(m_phase), m_phase);
                end
                tests++;
                if (32'(deal_pulse) + 32'(hit_pulse) + 32'(stand_pulse) > 1) begin
                    fails++;
                    $display("FAIL onehot t=%0t got %b%b%b want at most one", $time,
                             deal_pulse, hit_pulse, stand_pulse);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 0; left = 0; player_bust = 0; dealer_done = 0;
        step(); step();
        rst = 1;
        step();
    endtask

    task automatic click(input int x, input int y, input int hold);
        xpos = 12'(x); ypos = 12'(y);
        left = 1;
        repeat (hold) step();
        left = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit bad;
        rst = 0; left = 0;
        step(); step(); step();
        tests++;
        if ({deal_pulse, hit_pulse, stand_pulse, btn_en, phase} !== 8'b000_001_00) begin
            fails++;
            $display("FAIL reset_state got %b want 00000100",
                     {deal_pulse, hit_pulse, stand_pulse, btn_en, phase});
        end
        rst = 1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({deal_pulse, hit_pulse, stand_pulse, btn_en, phase} !== 8'b000_001_00) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reset_idle_hold got %b want 00000100",
                     {deal_pulse, hit_pulse, stand_pulse, btn_en, phase});
        end
    endtask

    task automatic test_deal();
        click(150, 420, 10);
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i < 7) begin
                tests++;
                if (deal_pulse !== 1'b0) begin
                    fails++;
                    $display("FAIL deal_early edge=%0d got 1 want 0", i);
                end
            end
        end
        tests++;
        if ({deal_pulse, phase, btn_en} !== {1'b1, 2'd1, 3'b110}) begin
            fails++;
            $display("FAIL deal_latency got p=%b ph=%0d en=%b want p=1 ph=1 en=110",
                     deal_pulse, phase, btn_en);
        end
        step();
        tests++;
        if (deal_pulse !== 1'b0) begin
            fails++;
            $display("FAIL deal_width got 1 want 0");
        end
    endtask

    task automatic test_drag_and_stand();
        bit seen;
        xpos = 350; ypos = 425; left = 1;
        repeat (10) step();
        ypos = 300;
        repeat (3) step();
        left = 0;
        seen = 0;
        repeat (12) begin step(); if (hit_pulse) seen = 1; end
        tests++;
        if (seen || phase !== 2'd1) begin
            fails++;
            $display("FAIL drag_off_hit got pulse=%b ph=%0d want pulse=0 ph=1", seen, phase);
        end
        click(520, 449, 10);
        repeat (7) step();
        tests++;
        if ({stand_pulse, phase, btn_en} !== {1'b1, 2'd2, 3'b000}) begin
            fails++;
            $display("FAIL stand_click got p=%b ph=%0d en=%b want p=1 ph=2 en=000",
                     stand_pulse, phase, btn_en);
        end
        step();
    endtask

    task automatic test_glitch_and_bounds();
        bit seen;
        do_reset();
        click(150, 420, 3);
        seen = 0;
        repeat (12) begin step(); if (deal_pulse) seen = 1; end
        tests++;
        if (seen || phase !== 2'd0) begin
            fails++;
            $display("FAIL glitch got pulse=%b ph=%0d want pulse=0 ph=0", seen, phase);
        end
        click(200, 420, 10);
        seen = 0;
        repeat (12) begin step(); if (deal_pulse) seen = 1; end
        tests++;
        if (seen || phase !== 2'd0) begin
            fails++;
            $display("FAIL bound_right got pulse=%b ph=%0d want pulse=0 ph=0", seen, phase);
        end
        click(150, 450, 10);
        seen = 0;
        repeat (12) begin step(); if (deal_pulse) seen = 1; end
        tests++;
        if (seen || phase !== 2'd0) begin
            fails++;
            $display("FAIL bound_bottom got pulse=%b ph=%0d want pulse=0 ph=0", seen, phase);
        end
        click(199, 449, 10);
        repeat (12) step();
        tests++;
        if (phase !== 2'd1) begin
            fails++;
            $display("FAIL bound_inside_corner got ph=%0d want 1", phase);
        end
    endtask

    task automatic test_bust_tie();
        click(520, 449, 10);
        repeat (6) step();
        player_bust = 1;
        step();
        player_bust = 0;
        tests++;
        if ({stand_pulse, phase, btn_en} !== {1'b1, 2'd3, 3'b001}) begin
            fails++;
            $display("FAIL bust_vs_stand got p=%b ph=%0d en=%b want p=1 ph=3 en=001",
                     stand_pulse, phase, btn_en);
        end
        dealer_done = 1;
        step();
        dealer_done = 0;
        step();
        tests++;
        if (phase !== 2'd3) begin
            fails++;
            $display("FAIL done_in_result got ph=%0d want 3", phase);
        end
        click(150, 420, 10);
        repeat (10) step();
        tests++;
        if (phase !== 2'd1 || btn_en !== 3'b110) begin
            fails++;
            $display("FAIL deal_from_result got ph=%0d en=%b want ph=1 en=110", phase, btn_en);
        end
    endtask

    task automatic test_reset_midpress();
        bit seen;
        do_reset();
        xpos = 150; ypos = 420; left = 1;
        repeat (10) step();
        rst = 0;
        step(); step();
        rst = 1; left = 0;
        seen = 0;
        repeat (15) begin step(); if (deal_pulse) seen = 1; end
        tests++;
        if (seen || phase !== 2'd0) begin
            fails++;
            $display("FAIL reset_midpress got pulse=%b ph=%0d want pulse=0 ph=0", seen, phase);
        end
    endtask

    task automatic test_random();
        int px[15] = '{150, 100, 199, 200, 150, 150, 350, 300, 399, 400, 520, 599, 600, 50, 550};
        int py[15] = '{420, 400, 449, 420, 450, 399, 425, 400, 449, 430, 449, 400, 420, 50, 300};
        int hold, k;
        do_reset();
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                left = 1'($urandom_range(0, 1));
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                   : int'($urandom_range(5, 14));
            end
            hold--;
            if ($urandom_range(0, 5) == 0) begin
                k = int'($urandom_range(0, 14));
                xpos = 12'(px[k]); ypos = 12'(py[k]);
            end
            player_bust = ($urandom_range(0, 40) == 0);
            dealer_done = ($urandom_range(0, 25) == 0);
            step();
        end
        player_bust = 0; dealer_done = 0; left = 0;
        repeat (12) step();
    endtask

    initial begin
        model_clear();
        test_reset();
        chk_en = 1'b1;
        test_deal();
        test_drag_and_stand();
        test_glitch_and_bounds();
        test_bust_tie();
        test_reset_midpress();
        test_random();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
